// File: rtl/multi_alarm_core.sv
// 24h BCD clock with NUM_ALARMS ring/snooze/timeout alarms.
// Digit, ringing and led outputs are registered (one cycle behind state). There is no backpressure: ticks and edits are consumed on arrival.
module multi_alarm_core #(
  parameter int NUM_ALARMS   = 4,
  parameter int SEC_PER_MIN  = 60,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MAX_MIN = 10
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic                  count_active,
  input  logic [2:0]            sel,
  input  logic                  inc_min,
  input  logic                  inc_hour,
  input  logic                  snooze,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  output logic [1:0]            hourten,
  output logic [3:0]            hour,
  output logic [2:0]            minten,
  output logic [3:0]            min,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  led
);
  localparam int SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;

  typedef struct packed {
    logic [1:0] ht;
    logic [3:0] ho;
    logic [2:0] mt;
    logic [3:0] mo;
  } bcd_time_t;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alm_state_t;

  // Minute increment wraps 59 -> 00 inside the minute digits only; callers add the hour carry.
  function automatic bcd_time_t bump_min(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.mo == 4'd9) begin
      r.mo = 4'd0;
      r.mt = (t.mt == 3'd5) ? 3'd0 : t.mt + 3'd1;
    end else begin
      r.mo = t.mo + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_time_t bump_hour(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.ht == 2'd2 && t.ho == 4'd3) begin
      r.ht = 2'd0;
      r.ho = 4'd0;
    end else if (t.ho == 4'd9) begin
      r.ho = 4'd0;
      r.ht = t.ht + 2'd1;
    end else begin
      r.ho = t.ho + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_time_t apply_edit(input bcd_time_t t, input logic dm, input logic dh);
    bcd_time_t r;
    r = t;
    if (dm) r = bump_min(r);
    if (dh) r = bump_hour(r);
    return r;
  endfunction

  bcd_time_t             tod, tod_adv, sel_time, disp;
  bcd_time_t             alm_time [NUM_ALARMS];
  alm_state_t            st       [NUM_ALARMS];
  alm_state_t            st_nxt   [NUM_ALARMS];
  logic [3:0]            cnt      [NUM_ALARMS];
  logic [3:0]            cnt_nxt  [NUM_ALARMS];
  logic [SW-1:0]         sec;
  logic                  inc_min_q, inc_hour_q, snooze_q;
  logic                  min_p, hour_p, snz_p, any_edit, tod_sel, tod_edit, madv;
  logic [NUM_ALARMS-1:0] alm_sel, ring_nxt;

  assign min_p    = inc_min & ~inc_min_q;
  assign hour_p   = inc_hour & ~inc_hour_q;
  assign snz_p    = snooze & ~snooze_q;
  assign any_edit = min_p | hour_p;

  always_comb begin
    alm_sel = '0;
    for (int k = 0; k < NUM_ALARMS; k++) alm_sel[k] = (sel == 3'(k + 1));
  end

  // sel values beyond the last alarm fall back to the time of day.
  assign tod_sel  = ~|alm_sel;
  assign tod_edit = tod_sel & any_edit;
  assign madv     = tick_1hz & count_active & ~tod_edit & (sec == SW'(SEC_PER_MIN - 1));
  assign tod_adv  = (tod.mt == 3'd5 && tod.mo == 4'd9) ? bump_hour(bump_min(tod)) : bump_min(tod);

  always_comb begin
    sel_time = tod;
    for (int k = 0; k < NUM_ALARMS; k++)
      if (alm_sel[k]) sel_time = alm_time[k];
  end

  // Dismiss beats snooze, snooze beats the minute countdown; a fresh match ignores snooze.
  always_comb begin
    ring_nxt = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      st_nxt[k]  = st[k];
      cnt_nxt[k] = cnt[k];
      if (!alarm_en[k]) begin
        st_nxt[k]  = IDLE;
        cnt_nxt[k] = 4'd0;
      end else begin
        case (st[k])
          IDLE: if (madv && tod_adv == alm_time[k]) begin
            st_nxt[k]  = RINGING;
            cnt_nxt[k] = 4'(RING_MAX_MIN);
          end
          RINGING: if (snz_p) begin
            st_nxt[k]  = SNOOZED;
            cnt_nxt[k] = 4'(SNOOZE_MIN);
          end else if (madv) begin
            if (cnt[k] <= 4'd1) begin
              st_nxt[k]  = IDLE;
              cnt_nxt[k] = 4'd0;
            end else begin
              cnt_nxt[k] = cnt[k] - 4'd1;
            end
          end
          SNOOZED: if (madv) begin
            if (cnt[k] <= 4'd1) begin
              st_nxt[k]  = RINGING;
              cnt_nxt[k] = 4'(RING_MAX_MIN);
            end else begin
              cnt_nxt[k] = cnt[k] - 4'd1;
            end
          end
          default: begin
            st_nxt[k]  = IDLE;
            cnt_nxt[k] = 4'd0;
          end
        endcase
      end
      ring_nxt[k] = (st_nxt[k] == RINGING);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      tod        <= '0;
      sec        <= '0;
      inc_min_q  <= 1'b0;
      inc_hour_q <= 1'b0;
      snooze_q   <= 1'b0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        alm_time[k] <= '0;
        st[k]       <= IDLE;
        cnt[k]      <= 4'd0;
      end
      disp    <= '0;
      ringing <= '0;
      led     <= 1'b0;
    end else begin
      inc_min_q  <= inc_min;
      inc_hour_q <= inc_hour;
      snooze_q   <= snooze;
      if (tod_edit) begin
        tod <= apply_edit(tod, min_p, hour_p);
        sec <= '0;
      end else if (tick_1hz && count_active) begin
        if (madv) begin
          sec <= '0;
          tod <= tod_adv;
        end else begin
          sec <= sec + SW'(1);
        end
      end
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (alm_sel[k] && any_edit) alm_time[k] <= apply_edit(alm_time[k], min_p, hour_p);
        st[k]  <= st_nxt[k];
        cnt[k] <= cnt_nxt[k];
      end
      disp    <= sel_time;
      ringing <= ring_nxt;
      led     <= |ring_nxt;
    end
  end

  assign {hourten, hour, minten, min} = disp;

endmodule

// File: tb/tb_multi_alarm_core.sv
// Directed bench for multi_alarm_core with short minutes, ring and snooze periods.
module tb_multi_alarm_core;
  localparam int NA = 4;

  logic          clk = 1'b0;
  logic          rst, tick_1hz, count_active, inc_min, inc_hour, snooze;
  logic [2:0]    sel;
  logic [NA-1:0] alarm_en;
  logic [1:0]    hourten;
  logic [3:0]    hour;
  logic [2:0]    minten;
  logic [3:0]    mins;
  logic [NA-1:0] ringing;
  logic          led;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_alarm_core #(
    .NUM_ALARMS(NA), .SEC_PER_MIN(2), .SNOOZE_MIN(2), .RING_MAX_MIN(3)
  ) dut (
    .CLK100MHZ(clk), .rst(rst), .tick_1hz(tick_1hz), .count_active(count_active),
    .sel(sel), .inc_min(inc_min), .inc_hour(inc_hour), .snooze(snooze),
    .alarm_en(alarm_en), .hourten(hourten), .hour(hour), .minten(minten),
    .min(mins), .ringing(ringing), .led(led)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hm(input int h, input int m);
    return {19'b0, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  task automatic check_disp(input string tag, input int h, input int m);
    @(negedge clk);
    chk(tag, {19'b0, hourten, hour, minten, mins}, hm(h, m));
  endtask

  task automatic check_ring(input string tag, input logic [NA-1:0] exp);
    chk(tag, 32'(ringing), 32'(exp));
    chk({tag, "_led"}, 32'(led), 32'(|exp));
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      inc_min = 1'b1;
      @(negedge clk);
      inc_min = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press_hour(input int n);
    repeat (n) begin
      inc_hour = 1'b1;
      @(negedge clk);
      inc_hour = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; count_active = 1'b0;
    inc_min = 1'b0; inc_hour = 1'b0; snooze = 1'b0;
    sel = 3'd0; alarm_en = '0;
    @(negedge clk);
    chk("rst_digits", {19'b0, hourten, hour, minten, mins}, 32'd0);
    check_ring("rst_ring", 4'b0000);
    rst = 1'b0;
    count_active = 1'b1;
    @(negedge clk);

    ticks(4);
    check_disp("four_ticks", 0, 2);
    press_hour(23);
    press_min(57);
    check_disp("set_2359", 23, 59);
    ticks(2);
    check_disp("wrap_midnight", 0, 0);

    press_min(3);
    check_disp("set_0003", 0, 3);
    ticks(1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_digits", {19'b0, hourten, hour, minten, mins}, 32'd0);
    check_ring("midrst_ring", 4'b0000);
    rst = 1'b0;
    ticks(1);
    check_disp("sec_cleared", 0, 0);
    ticks(1);
    check_disp("first_min", 0, 1);

    press_hour(12);
    press_min(58);
    check_disp("set_1259", 12, 59);
    inc_min = 1'b1;
    repeat (50) @(negedge clk);
    inc_min = 1'b0;
    check_disp("held_min_nocarry", 12, 0);
    press_hour(11);
    check_disp("set_2300", 23, 0);
    press_hour(1);
    check_disp("hour_wrap", 0, 0);

    ticks(1);
    tick_1hz = 1'b1; inc_min = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0; inc_min = 1'b0;
    check_disp("edit_beats_tick", 0, 1);
    ticks(1);
    check_disp("edit_cleared_sec", 0, 1);
    ticks(1);
    check_disp("after_edit_madv", 0, 2);

    sel = 3'd2;
    press_hour(7);
    press_min(30);
    check_disp("alarm1_0730", 7, 30);
    sel = 3'd1;
    press_hour(7);
    press_min(30);
    sel = 3'd0;
    press_hour(7);
    press_min(27);
    check_disp("set_0729", 7, 29);
    alarm_en = 4'b0010;
    ticks(1);
    check_ring("pre_match", 4'b0000);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    check_ring("match_a1", 4'b0010);
    @(negedge clk);

    ticks(4);
    check_ring("ring_2madv", 4'b0010);
    ticks(2);
    check_ring("ring_timeout", 4'b0000);
    sel = 3'd2;
    press_min(4);
    sel = 3'd0;
    ticks(2);
    check_ring("match_0734", 4'b0010);
    alarm_en = 4'b0000;
    @(negedge clk);
    check_ring("dismiss", 4'b0000);

    sel = 3'd2;
    press_min(2);
    sel = 3'd0;
    alarm_en = 4'b0010;
    ticks(4);
    check_ring("match_0736", 4'b0010);
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    check_ring("snoozed", 4'b0000);
    @(negedge clk);
    ticks(2);
    check_ring("snooze_1madv", 4'b0000);
    ticks(2);
    check_ring("rering", 4'b0010);
    ticks(4);
    check_ring("rering_2madv", 4'b0010);
    ticks(2);
    check_ring("rering_timeout", 4'b0000);

    sel = 3'd3;
    press_hour(5);
    check_disp("alarm2_0500", 5, 0);
    sel = 3'd0;
    check_disp("tod_untouched", 7, 41);
    sel = 3'd5;
    check_disp("sel5_is_tod", 7, 41);
    sel = 3'd3;
    press_hour(2);
    press_min(43);
    sel = 3'd1;
    press_min(13);
    sel = 3'd0;
    alarm_en = 4'b0101;
    ticks(4);
    check_ring("match_a0_a2", 4'b0101);
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    check_ring("snooze_both", 4'b0000);
    @(negedge clk);
    ticks(4);
    check_ring("rering_both", 4'b0101);

    alarm_en = 4'b0000;
    @(negedge clk);
    check_ring("dismiss_both", 4'b0000);
    sel = 3'd2;
    press_min(11);
    sel = 3'd0;
    alarm_en = 4'b0010;
    ticks(2);
    check_ring("pre_0747", 4'b0000);
    ticks(1);
    tick_1hz = 1'b1; snooze = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0; snooze = 1'b0;
    check_ring("match_beats_snooze", 4'b0010);
    check_disp("time_0747", 7, 47);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_alarm_core.md
Name: multi_alarm_core

Overview:
- Parametrised successor to the single-alarm timekeeping block.
- Keeps a 24-hour BCD time of day and holds NUM_ALARMS independently enabled alarms, each with ring, snooze and auto-timeout.
- Drives the four BCD digits consumed by disp and a ring indicator LED.
- Runs entirely on CLK100MHZ. The 1 Hz rate arrives as a single-cycle tick enable from derate; there are no derived clocks.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..7).
- SEC_PER_MIN, 60, ticks per minute (set small in simulation).
- SNOOZE_MIN, 5, minutes an alarm stays snoozed before re-ringing (1..15).
- RING_MAX_MIN, 10, minutes an alarm rings before it self-clears (1..15).

Ports:
- CLK100MHZ  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle enable, one per second.
- count_active  in  1  level; 1 = time advances on tick_1hz.
- sel  in  3  edit/display select: 0 = time of day, k = alarm k-1 (values > NUM_ALARMS behave as 0).
- inc_min  in  1  debounced level; rising edge detected internally.
- inc_hour  in  1  debounced level; rising edge detected internally.
- snooze  in  1  debounced level; rising edge detected internally.
- alarm_en  in  NUM_ALARMS  per-alarm enable level.
- hourten  out  2  BCD tens of hours of the selected item.
- hour  out  4  BCD hours of the selected item.
- minten  out  3  BCD tens of minutes of the selected item.
- min  out  4  BCD minutes of the selected item.
- ringing  out  NUM_ALARMS  per-alarm ringing flag.
- led  out  1  OR of ringing.

Behaviour:
- Reset (synchronous, active-high):
  - Time = 00:00 and second counter = 0.
  - All alarm times = 00:00 and all alarm states = IDLE.
  - Edge-detect registers cleared.
  - Every output reads 0 on the cycle after rst is sampled high.
  - Reset mid-ring or mid-snooze returns that alarm to IDLE.
- Edge detection: a registered copy of each button input; a press is in & ~prev. One edit per press, regardless of hold length.
- Timekeeping:
  - On tick_1hz with count_active = 1, the second counter increments.
  - On reaching SEC_PER_MIN-1 it wraps to 0 and a one-cycle "minute advance" (madv) is asserted.
  - madv carries minutes to hours: 23:59 -> 00:00.
  - BCD is kept digit-wise; no binary-to-BCD conversion is used.
- Editing (applies to the item chosen by sel):
  - inc_min: minutes +1, wrapping 59 -> 00 with no hour carry.
  - inc_hour: hours +1, wrapping 23 -> 00.
  - Editing the time of day also clears the second counter.
  - If an edit targets the time of day in the same cycle as a tick, the edit wins, the tick is dropped and no madv fires.
  - If inc_min and inc_hour edges coincide, both apply.
- Outputs: the digit outputs are registered and show the sel item one cycle after a sel change or update.
- Per-alarm FSM:
  - States are IDLE, RINGING and SNOOZED, each with a 4-bit minute counter.
  - IDLE -> RINGING: on madv, if alarm_en[k] = 1 and the new time equals alarm k. The counter loads RING_MAX_MIN.
  - Manual time edits never trigger an alarm.
  - RINGING -> SNOOZED: on a snooze edge. The counter loads SNOOZE_MIN. A snooze edge affects every alarm currently RINGING.
  - RINGING -> IDLE: when the counter, decremented on each madv, reaches 0.
  - SNOOZED -> RINGING: when the counter, decremented on each madv, reaches 0. The counter reloads RING_MAX_MIN.
  - Any state -> IDLE: when alarm_en[k] = 0 (dismiss). This has the highest priority, above snooze and match.
  - A match while SNOOZED or RINGING is ignored.
  - A snooze edge in the same cycle as an IDLE -> RINGING match does not snooze that alarm.
- ringing[k] = (state == RINGING), registered. led = |ringing.
- Editing alarm k's time while it is RINGING or SNOOZED does not change its state.

Test Plan:
- SEC_PER_MIN=2, rst, count_active=1, 4 ticks -> digits 00:02; set time to 23:59 via edits, then 2 ticks -> 00:00; assert rst mid-count -> all outputs 0 next cycle.
- sel=0, time 12:59, one inc_min press held 50 cycles -> 12:00 (no hour carry, a single increment); inc_hour at 23 -> 00; tick coincident with inc_min -> edit applied, seconds cleared, no madv.
- Alarm 1 = 07:30, alarm_en=4'b0010, time 07:29, 2 ticks -> ringing=4'b0010 and led=1 on the madv+1 cycle; alarm 0 also 07:30 but disabled -> stays 0.
- RING_MAX_MIN=3, ringing alarm left alone -> ringing clears after exactly 3 madv; ringing alarm, then alarm_en[1]=0 -> ringing[1]=0 next cycle.
- SNOOZE_MIN=2, ringing alarm, snooze edge -> ringing=0; after 2 madv -> ringing=1 again with counter = RING_MAX_MIN; snooze press while alarms 0 and 2 are both ringing -> both snoozed.
- sel=3, inc_hour x5 -> alarm 2 reads 05:00, time of day unchanged; sel=5 with NUM_ALARMS=4 -> time of day displayed.
